// File: rtl/cond_unit.sv
// Execute-stage condition evaluation, NZCV/sticky-Q status register and MRS/MSR word.
// Defining COND_QCOUNT_EN adds a saturating saturation-event counter (QCount/QCountClr).
module cond_unit #(
  parameter int QCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidE,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [3:0]        CondE,
  input  logic [1:0]        FlagWriteE,
  input  logic              QWriteE,
  input  logic              PsrWriteE,
  input  logic [31:0]       PsrWdata,
  input  logic [4:0]        ALUFlags,
  output logic              CondExE,
  output logic              CommitE,
  output logic              CondExM,
  output logic [3:0]        Flags,
  output logic              QFlag,
  output logic [31:0]       PsrRdata
`ifdef COND_QCOUNT_EN
  ,
  output logic [QCNT_W-1:0] QCount,
  input  logic              QCountClr
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       q_flag_q, q_flag_d;
  logic       cond_ex_m_q, cond_ex_m_d;
  logic       n, z, c, v;
  logic       cond_ex;

  assign {n, z, c, v} = flags_q;

  // Decode reads only the architectural flags; a CMP in cycle t is visible at t+1.
  always_comb begin
    cond_ex = 1'b0;
    case (CondE)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign CondExE = cond_ex;
  assign CommitE = ValidE & cond_ex & ~StallE & ~FlushE;

  always_comb begin
    flags_d  = flags_q;
    q_flag_d = q_flag_q;
    if (CommitE) begin
      if (PsrWriteE) begin
        flags_d  = PsrWdata[31:28];
        q_flag_d = PsrWdata[27];
      end else begin
        if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[4:3];
        if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[2:1];
        if (QWriteE && ALUFlags[0]) q_flag_d = 1'b1;
      end
    end
  end

  // CommitE is already low on a flush, so only the stall needs a hold path.
  assign cond_ex_m_d = StallE ? cond_ex_m_q : CommitE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q     <= 4'b0000;
      q_flag_q    <= 1'b0;
      cond_ex_m_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      q_flag_q    <= q_flag_d;
      cond_ex_m_q <= cond_ex_m_d;
    end
  end

  assign Flags    = flags_q;
  assign QFlag    = q_flag_q;
  assign CondExM  = cond_ex_m_q;
  assign PsrRdata = {flags_q, q_flag_q, 27'b0};

  logic unused_psr_bits;
  assign unused_psr_bits = ^PsrWdata[26:0];

`ifdef COND_QCOUNT_EN
  logic [QCNT_W-1:0] qcount_q, qcount_d;
  logic              q_evt;

  assign q_evt = CommitE & ~PsrWriteE & QWriteE & ALUFlags[0];

  always_comb begin
    qcount_d = qcount_q;
    if (QCountClr)
      qcount_d = '0;
    else if (q_evt && !(&qcount_q))
      qcount_d = qcount_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) qcount_q <= '0;
    else        qcount_q <= qcount_d;
  end

  assign QCount = qcount_q;
`else
  logic [QCNT_W-1:0] unused_qcnt_w;
  assign unused_qcnt_w = '0;
`endif

endmodule
